// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// spi_master_param : parametrised SPI master (width, divider, selects, mode).
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input (sample MOSI, not MISO).
// Rev 1.0
// ============================================================================
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_SS  = 1,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO_bit,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              SCLK,
  output logic              MOSI_bit,
  output logic [NUM_SS-1:0] SS,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int                EDGE_W    = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [NUM_SS-1:0]   ss_q, ss_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick;
  logic                sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : MISO_bit;
`else
  assign sample_bit = MISO_bit;
`endif

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      ss_q      <= '1;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      ss_q      <= ss_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    ss_d      = ss_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          sclk_d  = cpol;
          busy_d  = 1'b1;
          edge_d  = '0;
          state_d = SETUP;
          for (int i = 0; i < NUM_SS; i++) begin
            ss_d[i] = (ss_sel != SS_W'(i));
          end
          // Mode 0/2 presents the MSB before the first edge; 1/3 drives it on edge 1.
          if (!cpha) begin
            mosi_d  = tx_data[DATA_W-1];
            tx_sh_d = tx_data << 1;
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          // edge_q[0]==0 means a leading (odd-numbered) edge
          if (edge_q[0] == cpha_q) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
          end else if (edge_q != EDGE_LAST) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (edge_q == EDGE_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          sclk_d  = cpol_q;
          ss_d    = '1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        rx_data_d = rx_sh_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SCLK     = sclk_q;
  assign MOSI_bit = mosi_q;
  assign SS       = ss_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// tb_spi_master_param : directed bench for spi_master_param with an SPI slave model.
// Rev 1.0
// ============================================================================
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [1:0] ss_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       MISO_bit;
  logic       SCLK;
  logic       MOSI_bit;
  logic [3:0] SS;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // slave model state
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] slv_word = '0;
  logic [7:0] slv_sh;
  logic [7:0] slv_rx;
  logic [3:0] ss_prev = 4'hF;
  logic       sclk_prev = 1'b0;

  // per-transfer observations
  int         r_done_cyc, r_done_cnt, r_ss_low, r_ss_bad, r_busy_cnt;
  logic       r_sclk_setup;
  logic [3:0] r_ss_done;
  int         abort_done;

  spi_master_param #(
    .DATA_W (8),
    .CLK_DIV(2),
    .NUM_SS (4)
  ) dut (
    .clk_50M (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .ss_sel  (ss_sel),
    .cpol    (cpol),
    .cpha    (cpha),
    .MISO_bit(MISO_bit),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .SCLK    (SCLK),
    .MOSI_bit(MOSI_bit),
    .SS      (SS),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data)
  );

  always #10 clk = ~clk;

  // Slave: reacts half a clock after the master's outputs move.
  always @(negedge clk) begin
    ss_prev   <= SS;
    sclk_prev <= SCLK;
    if ((&ss_prev) && !(&SS)) begin
      if (!m_cpha) begin
        MISO_bit <= slv_word[7];
        slv_sh   <= slv_word << 1;
      end else begin
        slv_sh   <= slv_word;
      end
    end else if (!(&SS) && (SCLK != sclk_prev)) begin
      if ((SCLK != m_cpol) ^ m_cpha) begin
        slv_rx   <= {slv_rx[6:0], MOSI_bit};
      end else begin
        MISO_bit <= slv_sh[7];
        slv_sh   <= slv_sh << 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; inject raises start (with altered inputs) at edges 6, 21 and 37.
  task automatic run_xfer(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                          input logic pha, input logic [7:0] sword, input bit inject,
                          input int ncyc);
    @(negedge clk);
    tx_data = tx; ss_sel = sel; cpol = pol; cpha = pha;
    m_cpol = pol; m_cpha = pha; slv_word = sword; start = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    r_sclk_setup = SCLK;
    r_done_cyc   = -1;
    r_done_cnt   = 0;
    r_ss_done    = 4'h0;
    r_ss_low     = (SS[sel] == 1'b0) ? 1 : 0;
    r_ss_bad     = ((SS | (4'b1 << sel)) != 4'hF) ? 1 : 0;
    r_busy_cnt   = busy ? 1 : 0;
    for (int n = 1; n <= ncyc; n++) begin
      if (inject && (n == 6 || n == 21 || n == 37)) begin
        start = 1'b1; tx_data = 8'h00; cpol = ~pol; cpha = ~pha; ss_sel = sel + 2'd1;
      end else begin
        start = 1'b0; tx_data = tx; cpol = pol; cpha = pha; ss_sel = sel;
      end
      @(posedge clk); #1;
      if (!SS[sel]) r_ss_low++;
      if ((SS | (4'b1 << sel)) != 4'hF) r_ss_bad++;
      if (busy) r_busy_cnt++;
      if (n == 37) r_ss_done = SS;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = n;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(SCLK), 0);
    check("rst_mosi", 32'(MOSI_bit), 0);
    check("rst_ss", 32'(SS), 'hF);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rx", 32'(rx_data), 0);
    @(negedge clk);
    reset = 1'b1;

    // Mode 0 reference transfer
    run_xfer(8'hA5, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b0, 40);
    check("m0_sclk_setup", 32'(r_sclk_setup), 0);
    check("m0_done_cycle", r_done_cyc, 37);
    check("m0_done_count", r_done_cnt, 1);
    check("m0_ss0_low_cycles", r_ss_low, 36);
    check("m0_ss_other", r_ss_bad, 0);
    check("m0_busy_cycles", r_busy_cnt, 37);
    check("m0_rx", 32'(rx_data), 'h3C);
    check("m0_mosi_bits", 32'(slv_rx), 'hA5);
    check("m0_sclk_idle", 32'(SCLK), 0);

    // Modes 1..3
    for (int m = 1; m <= 3; m++) begin
      run_xfer(8'h81, 2'd0, m[1], m[0], 8'h7E, 1'b0, 40);
      check($sformatf("mode%0d_sclk_setup", m), 32'(r_sclk_setup), 32'(m[1]));
      check($sformatf("mode%0d_sclk_idle", m), 32'(SCLK), 32'(m[1]));
      check($sformatf("mode%0d_done_cycle", m), r_done_cyc, 37);
      check($sformatf("mode%0d_rx", m), 32'(rx_data), 'h7E);
      check($sformatf("mode%0d_mosi_bits", m), 32'(slv_rx), 'h81);
    end

    // Slave select decoding
    run_xfer(8'h55, 2'd2, 1'b0, 1'b0, 8'hAA, 1'b0, 40);
    check("ss2_low_cycles", r_ss_low, 36);
    check("ss2_other", r_ss_bad, 0);
    check("ss2_rx", 32'(rx_data), 'hAA);

    // Back-to-back on selects 3 then 2
    run_xfer(8'h12, 2'd3, 1'b0, 1'b0, 8'h34, 1'b0, 37);
    check("b2b_ss3_other", r_ss_bad, 0);
    check("b2b_ss_at_done", 32'(r_ss_done), 'hF);
    check("b2b_rx3", 32'(rx_data), 'h34);
    run_xfer(8'h56, 2'd2, 1'b0, 1'b0, 8'h78, 1'b0, 40);
    check("b2b_ss2_other", r_ss_bad, 0);
    check("b2b_ss2_low_cycles", r_ss_low, 36);
    check("b2b_rx2", 32'(rx_data), 'h78);

    // start while busy and in DONE cycle is ignored
    run_xfer(8'hC6, 2'd1, 1'b0, 1'b0, 8'h39, 1'b1, 40);
    check("ign_done_count", r_done_cnt, 1);
    check("ign_done_cycle", r_done_cyc, 37);
    check("ign_busy_cycles", r_busy_cnt, 37);
    check("ign_rx", 32'(rx_data), 'h39);
    check("ign_mosi_bits", 32'(slv_rx), 'hC6);
    check("ign_ss_other", r_ss_bad, 0);

    // Reset in the middle of XFER (edge 7), mode 3
    @(negedge clk);
    tx_data = 8'hF0; ss_sel = 2'd0; cpol = 1'b1; cpha = 1'b1;
    m_cpol = 1'b1; m_cpha = 1'b1; slv_word = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) abort_done++;
    end
    check("abort_busy_before", 32'(busy), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_sclk", 32'(SCLK), 0);
    check("abort_mosi", 32'(MOSI_bit), 0);
    check("abort_ss", 32'(SS), 'hF);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_rx", 32'(rx_data), 0);
    check("abort_no_done", abort_done, 0);
    @(negedge clk);
    reset = 1'b1;
    run_xfer(8'h3C, 2'd0, 1'b0, 1'b0, 8'hC3, 1'b0, 40);
    check("post_abort_done_cycle", r_done_cyc, 37);
    check("post_abort_rx", 32'(rx_data), 'hC3);
    check("post_abort_mosi_bits", 32'(slv_rx), 'h3C);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    run_xfer(8'h5A, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 40);
    check("loopback_rx", 32'(rx_data), 'h5A);
    check("loopback_done_cycle", r_done_cyc, 37);
    loopback = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
